// File: rtl/cell_revealer.sv
// Revealed/flag bitmap keeper for the minefield: serves open requests and runs the zero-cell flood reveal.
// Flag toggling is compiled in only when REVEALER_FLAGS_EN is defined; otherwise open_flag_i is ignored.
module cell_revealer #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16,
  localparam int CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH),
  localparam int CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT),
  localparam int CNT_WIDTH    = $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT+1)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][3:0] game_field_i,
  input  logic [CELL_X_WIDTH-1:0]                             field_width_i,
  input  logic [CELL_Y_WIDTH-1:0]                             field_height_i,
  input  logic                                                clear_i,
  input  logic                                                open_valid_i,
  output logic                                                open_ready_o,
  input  logic [CELL_X_WIDTH-1:0]                             open_x_i,
  input  logic [CELL_Y_WIDTH-1:0]                             open_y_i,
  input  logic                                                open_flag_i,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0]      revealed_o,
  output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0]      flagged_o,
  output logic                                                mine_hit_o,
  output logic [CNT_WIDTH-1:0]                                cells_revealed_o,
  output logic                                                open_done_o
);
  localparam int XE = CELL_X_WIDTH + 1;
  localparam int YE = CELL_Y_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SWEEP, S_DONE} state_t;

  state_t                                           r_state;
  logic [CELL_X_WIDTH-1:0]                          r_x, r_w, r_sx;
  logic [CELL_Y_WIDTH-1:0]                          r_y, r_h, r_sy;
  logic                                             r_flag, r_changed, r_mine, r_done;
  logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0]   r_revealed, r_flagged;
  logic [CNT_WIDTH-1:0]                             r_cnt;

  logic                    w_flag_req, w_ready, w_playable, w_sweep_src;
  logic [3:0]              w_cell_val, w_nb_cnt;
  logic [8:0]              w_nb_new;
  logic [XE-1:0]           w_nb_ex [9];
  logic [YE-1:0]           w_nb_ey [9];
  logic [CELL_X_WIDTH-1:0] w_nb_x [9];
  logic [CELL_Y_WIDTH-1:0] w_nb_y [9];

`ifdef REVEALER_FLAGS_EN
  assign w_flag_req = open_flag_i;
`else
  logic w_unused_flag;
  assign w_unused_flag = open_flag_i;
  assign w_flag_req    = 1'b0;
`endif

  // Handshake: a request is taken on the rising edge where open_valid_i && open_ready_o;
  // ready is high only in IDLE with no mine hit, and the requester holds x/y/flag until taken.
  assign w_ready    = (r_state == S_IDLE) && !r_mine;
  assign w_cell_val = game_field_i[r_x][r_y];
  assign w_playable = (r_x >= CELL_X_WIDTH'(1)) && (r_x < r_w) &&
                      (r_y >= CELL_Y_WIDTH'(1)) && (r_y < r_h);
  assign w_sweep_src = r_revealed[r_sx][r_sy] && (game_field_i[r_sx][r_sy] == 4'd0);

  // Neighbour coordinates carry one extra bit so x-1 at x=0 lands far out of range.
  always_comb begin
    w_nb_new = '0;
    w_nb_cnt = '0;
    for (int k = 0; k < 9; k++) begin
      w_nb_ex[k] = {1'b0, r_sx} + XE'(k % 3) - XE'(1);
      w_nb_ey[k] = {1'b0, r_sy} + YE'(k / 3) - YE'(1);
      w_nb_x[k]  = w_nb_ex[k][CELL_X_WIDTH-1:0];
      w_nb_y[k]  = w_nb_ey[k][CELL_Y_WIDTH-1:0];
      w_nb_new[k] = (k != 4) && w_sweep_src &&
                    (w_nb_ex[k] >= XE'(1)) && (w_nb_ex[k] < {1'b0, r_w}) &&
                    (w_nb_ey[k] >= YE'(1)) && (w_nb_ey[k] < {1'b0, r_h}) &&
                    !r_revealed[w_nb_x[k]][w_nb_y[k]] && !r_flagged[w_nb_x[k]][w_nb_y[k]];
      w_nb_cnt = w_nb_cnt + 4'(w_nb_new[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_flag     <= 1'b0;
      r_changed  <= 1'b0;
      r_mine     <= 1'b0;
      r_done     <= 1'b0;
      r_revealed <= '0;
      r_flagged  <= '0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (open_valid_i && w_ready) begin
            r_x     <= open_x_i;
            r_y     <= open_y_i;
            r_w     <= field_width_i;
            r_h     <= field_height_i;
            r_flag  <= w_flag_req;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          if (w_playable && !r_revealed[r_x][r_y]) begin
            if (r_flag) begin
              r_flagged[r_x][r_y] <= !r_flagged[r_x][r_y];
            end else if (!r_flagged[r_x][r_y]) begin
              r_revealed[r_x][r_y] <= 1'b1;
              r_cnt <= r_cnt + CNT_WIDTH'(1);
              if (w_cell_val == 4'd9) begin
                r_mine <= 1'b1;
              end else if (w_cell_val == 4'd0) begin
                r_state   <= S_SWEEP;
                r_done    <= 1'b0;
                r_sx      <= CELL_X_WIDTH'(1);
                r_sy      <= CELL_Y_WIDTH'(1);
                r_changed <= 1'b0;
              end
            end
          end
        end
        S_SWEEP: begin
          for (int k = 0; k < 9; k++) begin
            if (w_nb_new[k]) r_revealed[w_nb_x[k]][w_nb_y[k]] <= 1'b1;
          end
          r_cnt <= r_cnt + CNT_WIDTH'(w_nb_cnt);
          if (w_nb_cnt != 4'd0) r_changed <= 1'b1;
          if (r_sx == r_w - CELL_X_WIDTH'(1)) begin
            r_sx <= CELL_X_WIDTH'(1);
            if (r_sy == r_h - CELL_Y_WIDTH'(1)) begin
              // End of pass: rescan while anything changed, since reveals can feed earlier cells.
              if (r_changed || (w_nb_cnt != 4'd0)) begin
                r_sy      <= CELL_Y_WIDTH'(1);
                r_changed <= 1'b0;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_sy <= r_sy + CELL_Y_WIDTH'(1);
            end
          end else begin
            r_sx <= r_sx + CELL_X_WIDTH'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign open_ready_o     = w_ready;
  assign revealed_o       = r_revealed;
  assign flagged_o        = r_flagged;
  assign mine_hit_o       = r_mine;
  assign cells_revealed_o = r_cnt;
  assign open_done_o      = r_done;
endmodule

// File: doc/cell_revealer.md
Name: cell_revealer

Overview:
- Read-side companion to the minefield generator. Consumes the 4-bit game field (0-8 = neighbour mine count, 9 = mine) and serves player "open cell" requests.
- Maintains the revealed-cell bitmap, including the zero-cell cascade (flood reveal).
- Sits between the cursor/input controller and the SVGA renderer. The renderer reads revealed_o alongside game_field_i.

Parameters:
- MAX_CELL_WIDTH, 30, max field columns.
- MAX_CELL_HEIGHT, 16, max field rows.
- CELL_X_WIDTH (localparam), $clog2(MAX_CELL_WIDTH), x coordinate width.
- CELL_Y_WIDTH (localparam), $clog2(MAX_CELL_HEIGHT), y coordinate width.
- CNT_WIDTH (localparam), $clog2(MAX_CELL_WIDTH*MAX_CELL_HEIGHT+1), revealed-count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- game_field_i  in  4 x [MAX_CELL_WIDTH][MAX_CELL_HEIGHT]  field contents, indexed [x][y]; stable while block is busy
- field_width_i  in  CELL_X_WIDTH  active width, sampled at request accept
- field_height_i  in  CELL_Y_WIDTH  active height, sampled at request accept
- clear_i  in  1  new-game clear, single-cycle pulse
- open_valid_i  in  1  open request valid
- open_ready_o  out  1  request accepted when valid and ready
- open_x_i  in  CELL_X_WIDTH  request column
- open_y_i  in  CELL_Y_WIDTH  request row
- open_flag_i  in  1  request is a flag toggle, not an open (see Optional Feature)
- revealed_o  out  1 x [MAX_CELL_WIDTH][MAX_CELL_HEIGHT]  revealed bitmap
- flagged_o  out  1 x [MAX_CELL_WIDTH][MAX_CELL_HEIGHT]  flag bitmap
- mine_hit_o  out  1  sticky, a mine was opened
- cells_revealed_o  out  CNT_WIDTH  number of revealed cells
- open_done_o  out  1  one-cycle pulse, request fully processed

Behaviour:
- Playable cell: 1 <= x < W and 1 <= y < H, where W/H are the latched width/height. Non-playable cells are never revealed or flagged.
- Reset (rst=0) or clear_i=1, any state, next edge:
  - state IDLE; revealed_o, flagged_o, mine_hit_o, cells_revealed_o all 0; open_done_o 0.
  - clear_i has priority over any in-flight request, which is abandoned.
- open_ready_o = (state==IDLE) && !mine_hit_o. Once a mine is hit, requests stall until clear.
- FSM states: IDLE, CHECK, SWEEP, DONE.
- IDLE -> CHECK on accept. Latch x, y, W, H and flag bit.
- CHECK, one cycle. Applied in this order:
  - Non-playable or already revealed: no change -> DONE.
  - Flagged: no change -> DONE.
  - Value 9: reveal, set mine_hit_o -> DONE.
  - Value 1-8: reveal -> DONE.
  - Value 0: reveal -> SWEEP.
- SWEEP:
  - Scan pointer visits playable cells one per cycle, y outer, x inner, starting at (1,1).
  - If the visited cell is revealed and has value 0, reveal all 8 neighbours that are playable, unrevealed and unflagged, in that cycle.
  - Any new reveal in a pass sets a changed flag.
  - After cell (W-1,H-1): if changed, clear the flag and restart at (1,1); else -> DONE.
  - Neighbour index arithmetic is done at CELL_X_WIDTH+1 / CELL_Y_WIDTH+1 bits so x-1 at x=0 does not wrap into range.
- DONE: open_done_o=1 for one cycle -> IDLE.
- Counter: cells_revealed_o increments by the number of newly revealed cells each cycle (0-8 in SWEEP, 0-1 in CHECK). It never exceeds (W-1)*(H-1).
- Latency:
  - Non-zero cell: accept -> done pulse in 2 cycles.
  - Zero cell: 2 + P*(W-1)*(H-1) cycles, where P is the number of passes (>=1).

Optional Feature:
- Macro REVEALER_FLAGS_EN.
- Defined: a request with open_flag_i=1 toggles flagged_o at (x,y) in CHECK if the cell is playable and unrevealed, then -> DONE. Flagged cells are skipped by opens and by the cascade.
- Undefined: open_flag_i is ignored (every request is an open); flagged_o is constant 0.

Test Plan:
- Reset, then open (3,3) holding value 2 on a 10x8 field -> revealed_o[3][3]=1, cells_revealed_o=1, open_done_o pulse 2 cycles after accept, mine_hit_o=0.
- Open (5,4) holding value 9 -> mine_hit_o=1, open_ready_o=0. A further open_valid_i is not accepted until clear_i pulse, after which all outputs are 0.
- 10x8 field with no mines (all 0), open (1,1) -> all 63 playable cells revealed, cells_revealed_o=63, row 0 / column 0 stay unrevealed, done after >=1 pass.
- Field with a mine column at x=5 (neighbours marked), open (2,2) -> only x=1..4 revealed plus the count cells at x=4. Nothing at x>=6 is revealed.
- Open an already-revealed cell, and open (0,3) or (10,3) on W=10 -> no change, done pulse in 2 cycles.
- REVEALER_FLAGS_EN: flag (2,2) then open (1,1) on the all-zero field -> cells_revealed_o=62, revealed_o[2][2]=0. Flag again toggles it off.
